// File: rtl/bitty_sequencer.sv
// Multi-cycle instruction sequencer for the BittyPro datapath.
// Latches one instruction per handshake and steps it through LOAD_S, LOAD_C and WRITE.
module bitty_sequencer #(
    parameter int NREG  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [15:0]      inst,
    input  logic             inst_valid,
    output logic             inst_ready,
    output logic [2:0]       mux_sel,
    output logic [3:0]       sel,
    output logic             mode,
    output logic             en_s,
    output logic             en_c,
    output logic [NREG-1:0]  en_i,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_S = 2'd1,
        ST_LOAD_C = 2'd2,
        ST_WRITE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_inst_q;
    logic [CNT_W-1:0] r_retired;
    logic             w_accept;
    logic             w_unused_bits;

    // WRITE also accepts, so a held-valid stream overlaps retire with the next load.
    assign inst_ready    = (r_state == ST_IDLE) || (r_state == ST_WRITE);
    assign w_accept      = inst_valid && inst_ready;
    assign busy          = (r_state != ST_IDLE);
    assign retired       = r_retired;
    assign w_unused_bits = ^{r_inst_q[9:6], r_inst_q[0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_inst_q  <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_inst_q <= inst;
            end
            if (r_state == ST_WRITE) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mux_sel     = 3'd0;
        sel         = 4'd0;
        mode        = 1'b0;
        en_s        = 1'b0;
        en_c        = 1'b0;
        en_i        = '0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_LOAD_S;
                end
            end
            ST_LOAD_S: begin
                mux_sel     = r_inst_q[15:13];
                en_s        = 1'b1;
                w_state_nxt = ST_LOAD_C;
            end
            ST_LOAD_C: begin
                mux_sel     = r_inst_q[12:10];
                sel         = r_inst_q[5:2];
                mode        = r_inst_q[1];
                en_c        = 1'b1;
                w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                en_i        = NREG'(1) << r_inst_q[15:13];
                done        = 1'b1;
                w_state_nxt = w_accept ? ST_LOAD_S : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
